// File: rtl/dino_jump_ctrl.sv
// Dino jump controller: turns a debounced press pulse into a per-frame
// integer-gravity trajectory, exposing height and sprite/collision flags.
module dino_jump_ctrl #(
  parameter int H_W     = 8,
  parameter int V_W     = 8,
  parameter int JUMP_V0 = 12,
  parameter int GRAVITY = 1,
  parameter int MAX_H   = 100
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_frame_tick,
  input  logic           i_jump_pulse,
  input  logic           i_game_active,
  output logic [H_W-1:0] o_height,
  output logic           o_airborne,
  output logic           o_falling,
  output logic           o_jump_start,
  output logic           o_landed
);

  typedef enum logic [1:0] {GROUND, ARMED, RISING, FALLING} state_e;

  localparam int SW = H_W + 2;
  localparam logic signed [SW-1:0]  MAXH_S  = SW'(MAX_H);
  localparam logic [H_W-1:0]        H_START = H_W'((JUMP_V0 > MAX_H) ? MAX_H : JUMP_V0);
  localparam logic signed [V_W-1:0] V_START = V_W'(JUMP_V0 - GRAVITY);
  localparam logic signed [V_W:0]   GRAV_X  = (V_W+1)'(GRAVITY);
  localparam logic signed [V_W:0]   VMIN_X  = {2'b11, {(V_W-1){1'b0}}};

  state_e                state_q, state_d;
  logic [H_W-1:0]        height_q, height_d;
  logic signed [V_W-1:0] vel_q, vel_d;
  logic                  js_q, js_d, land_q, land_d;
  logic                  air_q, air_d, fall_q, fall_d;

  logic signed [SW-1:0]  sum;
  logic signed [V_W:0]   vel_dec;
  logic signed [V_W-1:0] vel_next;
  logic                  start;

  // Sum is formed wide enough that a negative velocity can never wrap it.
  assign sum      = $signed({2'b00, height_q}) + SW'(vel_q);
  assign vel_dec  = (V_W+1)'(vel_q) - GRAV_X;
  assign vel_next = (vel_dec < VMIN_X) ? VMIN_X[V_W-1:0] : vel_dec[V_W-1:0];
  assign start    = i_game_active && i_frame_tick &&
                    (((state_q == GROUND) && i_jump_pulse) || (state_q == ARMED));

  always_comb begin
    state_d  = state_q;
    height_d = height_q;
    vel_d    = vel_q;
    js_d     = 1'b0;
    land_d   = 1'b0;
    if (!i_game_active) begin
      if (state_q == ARMED) state_d = GROUND;
    end else if (start) begin
      state_d  = RISING;
      height_d = H_START;
      vel_d    = V_START;
      js_d     = 1'b1;
    end else begin
      case (state_q)
        GROUND: if (i_jump_pulse) state_d = ARMED;
        RISING, FALLING: begin
          if (i_frame_tick) begin
            if (sum[SW-1] || (sum == '0)) begin
              state_d  = GROUND;
              height_d = '0;
              vel_d    = '0;
              land_d   = 1'b1;
            end else if (sum > MAXH_S) begin
              state_d  = RISING;
              height_d = H_W'(MAX_H);
              vel_d    = '0;
            end else begin
              height_d = sum[H_W-1:0];
              vel_d    = vel_next;
              state_d  = vel_next[V_W-1] ? FALLING : RISING;
            end
          end
        end
        default: ;
      endcase
    end
    air_d  = (state_d == RISING) || (state_d == FALLING);
    fall_d = (state_d == FALLING);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= GROUND;
      height_q <= '0;
      vel_q    <= '0;
      js_q     <= 1'b0;
      land_q   <= 1'b0;
      air_q    <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      height_q <= height_d;
      vel_q    <= vel_d;
      js_q     <= js_d;
      land_q   <= land_d;
      air_q    <= air_d;
      fall_q   <= fall_d;
    end
  end

  assign o_height     = height_q;
  assign o_airborne   = air_q;
  assign o_falling    = fall_q;
  assign o_jump_start = js_q;
  assign o_landed     = land_q;

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Directed bench for dino_jump_ctrl: default trajectory plus a MAX_H=50 instance.
module tb_dino_jump_ctrl;

  logic       i_clk, i_rst, i_frame_tick, i_jump_pulse, i_game_active;
  logic [7:0] o_height, h50;
  logic       o_airborne, o_falling, o_jump_start, o_landed;
  logic       air50, fall50, js50, land50;

  int n_chk = 0;
  int n_err = 0;

  int exp_h [1:25] = '{12, 23, 33, 42, 50, 57, 63, 68, 72, 75, 77, 78, 78,
                       77, 75, 72, 68, 63, 57, 50, 42, 33, 23, 12, 0};
  int exp50 [1:10] = '{12, 23, 33, 42, 50, 50, 50, 49, 47, 44};

  dino_jump_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_frame_tick(i_frame_tick),
    .i_jump_pulse(i_jump_pulse), .i_game_active(i_game_active),
    .o_height(o_height), .o_airborne(o_airborne), .o_falling(o_falling),
    .o_jump_start(o_jump_start), .o_landed(o_landed)
  );

  dino_jump_ctrl #(.MAX_H(50)) dut50 (
    .i_clk(i_clk), .i_rst(i_rst), .i_frame_tick(i_frame_tick),
    .i_jump_pulse(i_jump_pulse), .i_game_active(i_game_active),
    .o_height(h50), .o_airborne(air50), .o_falling(fall50),
    .o_jump_start(js50), .o_landed(land50)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs from a negedge; returns at the following negedge.
  task automatic step(input logic tk, input logic jp, input logic rs);
    i_frame_tick = tk;
    i_jump_pulse = jp;
    i_rst        = rs;
    @(negedge i_clk);
    i_frame_tick = 1'b0;
    i_jump_pulse = 1'b0;
    i_rst        = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
  endtask

  // Ticks 2..25 of a default jump; optional pulses on ticks 3, 20 and the landing tick.
  task automatic fly(input bit mid);
    for (int k = 2; k <= 25; k++) begin
      idle(1);
      step(1'b1, mid && (k == 3 || k == 20 || k == 25), 1'b0);
      chk($sformatf("h_t%0d", k), o_height, exp_h[k]);
      chk($sformatf("fall_t%0d", k), o_falling, (k >= 13 && k <= 24) ? 1 : 0);
      chk($sformatf("air_t%0d", k), o_airborne, (k < 25) ? 1 : 0);
      chk($sformatf("land_t%0d", k), o_landed, (k == 25) ? 1 : 0);
      chk($sformatf("js_t%0d", k), o_jump_start, 0);
    end
  endtask

  initial begin
    int maxh, land_tk;
    i_rst = 1'b0; i_frame_tick = 1'b0; i_jump_pulse = 1'b0; i_game_active = 1'b1;
    @(negedge i_clk);

    // Reset and idle ticks
    do_reset();
    chk("rst_h", o_height, 0);
    chk("rst_flags", {o_airborne, o_falling, o_jump_start, o_landed}, 0);
    for (int k = 0; k < 10; k++) begin
      idle(1);
      step(1'b1, 1'b0, 1'b0);
      chk("idle_h", o_height, 0);
      chk("idle_flags", {o_airborne, o_falling, o_jump_start, o_landed}, 0);
    end

    // Pulse, then a tick five cycles later
    step(1'b0, 1'b1, 1'b0);
    idle(4);
    step(1'b1, 1'b0, 1'b0);
    chk("arm_js", o_jump_start, 1);
    chk("arm_h", o_height, 12);
    chk("arm_air", o_airborne, 1);
    idle(1);
    chk("js_one_cycle", o_jump_start, 0);
    chk("h_hold", o_height, 12);
    fly(1'b0);

    // Same-cycle pulse+tick, mid-air pulses ignored, pulse on landing ignored
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    chk("same_js", o_jump_start, 1);
    chk("same_h", o_height, 12);
    fly(1'b1);
    idle(1);
    step(1'b1, 1'b0, 1'b0);
    chk("post_land_js", o_jump_start, 0);
    chk("post_land_h", o_height, 0);

    // Extra pulses while armed are absorbed into a single jump
    do_reset();
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("absorb_h1", o_height, 12);
    idle(1);
    step(1'b1, 1'b0, 1'b0);
    chk("absorb_h2", o_height, 23);

    // Ceiling clamp on the MAX_H=50 instance
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    chk("m50_js", js50, 1);
    chk("m50_h1", h50, exp50[1]);
    maxh = 12; land_tk = 0;
    for (int k = 2; k <= 40 && land_tk == 0; k++) begin
      idle(1);
      step(1'b1, 1'b0, 1'b0);
      if (k <= 10) chk($sformatf("m50_h%0d", k), h50, exp50[k]);
      if (k == 7) chk("m50_fall7", fall50, 1);
      if (int'(h50) > maxh) maxh = int'(h50);
      if (land50) land_tk = k;
    end
    chk("m50_peak", maxh, 50);
    chk("m50_land_tick", land_tk, 17);

    // Freeze while the game is inactive
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    for (int k = 2; k <= 6; k++) begin
      idle(1);
      step(1'b1, 1'b0, 1'b0);
    end
    chk("frz_h6", o_height, 57);
    i_game_active = 1'b0;
    for (int k = 0; k < 10; k++) begin
      idle(1);
      step(1'b1, 1'b1, 1'b0);
      chk("frz_h", o_height, 57);
      chk("frz_air", o_airborne, 1);
    end
    i_game_active = 1'b1;
    idle(1);
    step(1'b1, 1'b0, 1'b0);
    chk("frz_resume", o_height, 63);

    // An armed request is dropped when the game goes inactive
    do_reset();
    step(1'b0, 1'b1, 1'b0);
    i_game_active = 1'b0;
    idle(2);
    i_game_active = 1'b1;
    idle(1);
    step(1'b1, 1'b0, 1'b0);
    chk("disarm_js", o_jump_start, 0);
    chk("disarm_h", o_height, 0);

    // Reset mid-jump overrides the coincident tick
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    for (int k = 2; k <= 7; k++) begin
      idle(1);
      step(1'b1, 1'b0, 1'b0);
    end
    chk("rstm_h7", o_height, 63);
    idle(1);
    step(1'b1, 1'b1, 1'b1);
    chk("rstm_h", o_height, 0);
    chk("rstm_flags", {o_airborne, o_falling, o_jump_start, o_landed}, 0);
    idle(1);
    step(1'b1, 1'b1, 1'b0);
    chk("rstm_js", o_jump_start, 1);
    chk("rstm_h1", o_height, 12);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dino_jump_ctrl.md
Name: dino_jump_ctrl

Overview:
- Game-side consumer of the one-cycle, debounced button-press pulse.
- Turns each press into a jump trajectory for the dino sprite using per-frame integer gravity. Outputs the dino's height above ground plus state flags for sprite selection and collision.
- Sits between the button input handler and the renderer/collision logic. Advances only on the frame tick.

Parameters:
- H_W, 8, width of the height output (unsigned).
- V_W, 8, width of the internal signed velocity register.
- JUMP_V0, 12, initial upward velocity in pixels/frame (positive, < 2^(V_W-1)).
- GRAVITY, 1, velocity decrement per frame (positive).
- MAX_H, 100, height ceiling in pixels (≤ 2^H_W − 1).

Ports:
- i_clk  in  1  system clock; the only clock.
- i_rst  in  1  synchronous, active-high reset.
- i_frame_tick  in  1  one-cycle pulse, once per video frame.
- i_jump_pulse  in  1  one-cycle debounced press pulse.
- i_game_active  in  1  level; high while game is running.
- o_height  out  H_W  dino height above ground in pixels.
- o_airborne  out  1  high while state is RISING or FALLING.
- o_falling  out  1  high while state is FALLING.
- o_jump_start  out  1  one-cycle pulse on the tick a jump begins.
- o_landed  out  1  one-cycle pulse on the tick the dino touches ground.

Behaviour:
- States: GROUND, ARMED, RISING, FALLING.
- Reset (sync, i_rst high at posedge): state GROUND; height 0; vel 0; all outputs 0. Reset overrides any other event in the same cycle, including mid-jump.
- i_game_active low: state, height and vel freeze; i_jump_pulse and i_frame_tick are ignored; any ARMED request returns to GROUND. Resuming continues from the frozen values.
- GROUND + i_jump_pulse, no tick in the same cycle: go to ARMED. Extra pulses while ARMED are absorbed; there is no queue.
- Jump start: on a tick while ARMED, or on a tick coinciding with a pulse in GROUND:
  - height <= JUMP_V0 (clamped to MAX_H);
  - vel <= JUMP_V0 − GRAVITY;
  - state RISING;
  - o_jump_start = 1 for that cycle.
- Airborne tick (RISING or FALLING):
  - sum = height + vel, computed signed at H_W+2 bits.
  - sum ≤ 0: height 0, vel 0, state GROUND, o_landed = 1 for one cycle.
  - sum > MAX_H: height MAX_H, vel 0, state RISING.
  - Otherwise: height <= sum, vel <= vel − GRAVITY.
  - State after a non-landing tick is FALLING if the new vel < 0, else RISING.
  - Velocity saturates at −2^(V_W−1); no wrap.
- i_jump_pulse while airborne: ignored. No double jump, no buffering.
- Pulse and landing tick in the same cycle: the landing completes and the pulse is ignored.
- Between ticks, height and vel hold; o_airborne and o_falling are registered and reflect the current state.
- Latency: o_jump_start and the first nonzero height appear 1 cycle after the qualifying tick edge.

Test Plan:
- Reset, no stimulus for 10 ticks → o_height 0, o_airborne 0, no pulses.
- Defaults: pulse in GROUND, then a tick 5 cycles later → o_jump_start on that tick.
  - Heights on successive ticks: 12, 23, 33, 42, 50, 57, 63, 68, 72, 75, 77, 78, 78, 77, 75, … 23, 12.
  - o_falling rises on tick 13.
  - o_landed plus height 0 on tick 25.
- Pulse and tick in the same cycle in GROUND → jump starts on that tick (height 12). Pulses at ticks 3 and 20 mid-air → trajectory unchanged, lands on tick 25.
- MAX_H=50 → heights 12, 23, 33, 42, 50, 50, 50, 49, 47, … (vel forced to 0 at the clamp). Height never exceeds 50.
- i_game_active dropped at tick 6 (height 57) for 10 ticks → height stays 57. After re-assert, the next tick gives 63.
- i_rst asserted at tick 8 mid-jump → next cycle height 0, state GROUND. A pulse plus tick afterwards starts a fresh jump at height 12.
